// File: rtl/trans_counter_pkg.sv
// trans_counter_pkg: shared parameter defaults and readout address map helpers
package trans_counter_pkg;
  localparam int NUM_PWR_CNTR = 4;
  localparam int CNT_W = 32;
  localparam int N_DIR = 2;
  function automatic int addr_total(input int nch);
    return nch;
  endfunction
  function automatic int addr_status(input int nch);
    return nch + 1;
  endfunction
endpackage

// File: rtl/trans_counter_if.sv
// trans_counter_if: monitor bus (iSig/ENB/CLR/dir/LE in, dato/valid out); master=tester, slave=counter
interface trans_counter_if import trans_counter_pkg::*; #(
  parameter int NCH = NUM_PWR_CNTR,
  parameter int CW = CNT_W,
  parameter int NDIR = N_DIR
) ();
  logic [NCH-1:0] iSig;
  logic ENB;
  logic CLR;
  logic [NDIR:0] dir;
  logic LE;
  logic [CW-1:0] dato;
  logic valid;
  modport master (output iSig, ENB, CLR, dir, LE, input dato, valid);
  modport slave (input iSig, ENB, CLR, dir, LE, output dato, valid);
endinterface

// File: rtl/trans_cnt_ch.sv
// trans_cnt_ch: one channel (CLK, RESET_L, sig/primed/enb/clr in; tog, saturating cnt, sticky sat out)
module trans_cnt_ch import trans_counter_pkg::*; #(
  parameter int CW = CNT_W
) (
  input  logic          CLK,
  input  logic          RESET_L,
  input  logic          sig_i,
  input  logic          primed_i,
  input  logic          enb_i,
  input  logic          clr_i,
  output logic          tog_o,
  output logic [CW-1:0] cnt_o,
  output logic          sat_o
);
  logic prev_q, sat_q, sat_d, inc, full;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tog_o = (sig_i ^ prev_q) & primed_i;
    inc = enb_i & tog_o;
    full = &cnt_q;
    cnt_d = clr_i ? '0 : (inc & !full) ? cnt_q + CW'(1) : cnt_q;
    sat_d = !clr_i & (sat_q | (inc & full));
  end
  always_ff @(posedge CLK) begin
    prev_q <= sig_i;
    if (!RESET_L) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end
  assign cnt_o = cnt_q;
  assign sat_o = sat_q;
endmodule

// File: rtl/trans_counter.sv
// trans_counter: per-channel + total transition counters, readout via bus (CLK, RESET_L, slave bus)
module trans_counter import trans_counter_pkg::*; #(
  parameter int NCH = NUM_PWR_CNTR,
  parameter int CW = CNT_W,
  parameter int NDIR = N_DIR
) (
  input logic CLK,
  input logic RESET_L,
  trans_counter_if.slave bus
);
  localparam logic [NDIR:0] A_TOT = (NDIR+1)'(addr_total(NCH));
  localparam logic [NDIR:0] A_ST = (NDIR+1)'(addr_status(NCH));
  logic primed_q, sat_tot_q, sat_tot_d, valid_q;
  logic [NCH-1:0] tog, sat;
  logic [NCH-1:0][CW-1:0] cnt;
  logic [CW-1:0] tot_q, tot_d, rd, dato_q, dato_d;
  logic [CW:0] sum;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    trans_cnt_ch #(.CW(CW)) u_ch (
      .CLK(CLK), .RESET_L(RESET_L), .sig_i(bus.iSig[i]), .primed_i(primed_q),
      .enb_i(bus.ENB), .clr_i(bus.CLR), .tog_o(tog[i]), .cnt_o(cnt[i]), .sat_o(sat[i])
    );
  end
  always_comb begin
    sum = {1'b0, tot_q};
    for (int i = 0; i < NCH; i++) sum = sum + (CW+1)'(tog[i]);
    tot_d = bus.CLR ? '0 : !bus.ENB ? tot_q : sum[CW] ? '1 : sum[CW-1:0];
    sat_tot_d = !bus.CLR & (sat_tot_q | (bus.ENB & sum[CW]));
    rd = '0;
    for (int i = 0; i < NCH; i++) if (bus.dir == (NDIR+1)'(i)) rd = cnt[i];
    if (bus.dir == A_TOT) rd = tot_q;
    if (bus.dir == A_ST) rd = CW'({sat_tot_q, sat});
    dato_d = bus.LE ? rd : dato_q;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      primed_q <= 1'b0;
      tot_q <= '0;
      sat_tot_q <= 1'b0;
      dato_q <= '0;
      valid_q <= 1'b0;
    end else begin
      primed_q <= 1'b1;
      tot_q <= tot_d;
      sat_tot_q <= sat_tot_d;
      dato_q <= dato_d;
      valid_q <= bus.LE;
    end
  end
  assign bus.dato = dato_q;
  assign bus.valid = valid_q;
endmodule

// File: doc/trans_counter.md
Name: trans_counter

Overview:
- Downstream monitor stage for the cell library bench. It consumes the cell outputs (oNand, oNor, oNot, oMux, ...) and counts output transitions per cell as a switching-activity/power proxy.
- Provides one saturating counter per channel, a total counter and a sticky saturation status word.
- Results are read out through a dir/dato address interface. The bench tester reads it after stimulus completes.

Parameters:
- NCH, 4, number of monitored channels (one per cell output); legal range 1..6 so the address map fits with NDIR=2.
- CW, 32, counter width in bits; also the width of dato.
- NDIR, 2, dir port is NDIR+1 bits wide (8 addresses at default).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET_L  input  1  synchronous active-low reset.
- iSig  input  NCH  monitored cell outputs; bit i = channel i.
- ENB  input  1  count enable; when low, counters hold but edge history still tracks.
- CLR  input  1  synchronous clear of all counters and saturation flags.
- dir  input  NDIR+1  readout address.
- LE  input  1  read strobe; one-cycle pulse requests a read of dir.
- dato  output  CW  read data.
- valid  output  1  high for exactly one cycle when dato holds a fresh read.

Behaviour:
- Reset (RESET_L=0 at a CLK edge):
  - All counters, the total counter, saturation flags, dato and valid go to 0.
  - The primed flag goes to 0.
- Edge history:
  - prev[NCH-1:0] <= iSig every cycle.
  - The first cycle after reset only loads prev and sets primed=1; no counting happens in that cycle.
- Toggle detection: tog = (iSig ^ prev) & {NCH{primed}}. Only the level differs from the last sample matters; a glitch between edges is invisible by design.
- Channel counter i:
  - If CLR: set to 0.
  - Else if ENB and tog[i]: increment by 1, saturating at 2^CW-1.
  - On an increment attempt while at max, the counter holds and sat[i] sets. sat[i] is sticky until CLR or reset.
- Total counter:
  - If CLR: set to 0.
  - Else if ENB: add popcount(tog), 0..NCH per cycle.
  - Saturates at 2^CW-1. If the sum would overflow, it holds max and sets sat_tot, which is sticky.
- Priority: reset > CLR > count. CLR in the same cycle as a toggle yields 0, not 1. prev still updates during CLR.
- Readout:
  - LE sampled at edge k gives dato/valid updated at edge k+1 (latency 1).
  - dato reflects counter values before any increment at edge k, i.e. a pre-update snapshot.
  - dato holds its value until the next read or reset. valid=0 when no read is pending.
- Address map:
  - dir 0..NCH-1: channel count.
  - dir NCH: total count.
  - dir NCH+1: status word; bits[NCH-1:0]=sat[], bit NCH=sat_tot, others 0.
  - Any higher dir: 0, with valid still asserted.
- Back-to-back LE: each cycle's strobe is serviced, so valid may stay high for consecutive cycles.
- LE with CLR in the same cycle: returns pre-clear value.
- Reset mid-read: valid clears; the pending read is discarded.

Decomposition:
- Shared package/header trans_counter_defs:
  - Address constants ADDR_TOTAL=NCH and ADDR_STATUS=NCH+1.
  - Defaults for NCH/CW/NDIR (NumPwrCntr, Ndir macros).
- One sub-module trans_cnt_ch:
  - Contains the prev flop, toggle detect, saturating counter and sticky sat bit.
  - Instantiated NCH times via generate.
  - It exports tog for the popcount.
- The top holds the total counter, readout mux and registered dato/valid.

Test Plan:
- Reset then priming: hold RESET_L=0 2 cycles with iSig=4'b1010, release, and keep iSig constant 5 cycles. Then read dir 0..5. Required: all reads return 0, and exactly one valid pulse per LE.
- Toggle counting: ENB=1, toggle iSig[0] every cycle for 10 cycles and iSig[2] every other cycle for 10 cycles. Required: dir0=10, dir2=5, dir1=dir3=0, dir4=15.
- Enable gating: ENB=0 while toggling iSig[1] 6 times, then ENB=1 and toggle 3 times. Required: dir1=3; toggles during ENB=0 are not counted, and there is no spurious count on re-enable.
- Saturation: with CW=4, toggle ch0 20 times. Required: dir0=15, dir5 bit0=1. Then CLR pulse: dir0=0 and dir5=0.
- Read timing and priority: LE with dir=0 in the same cycle as a ch0 toggle and count=7. Required: dato=7 with valid high the next cycle, and a following read returns 8. Also CLR together with a toggle: count=0.
- Out-of-range and reset mid-read: LE with dir=7 gives dato=0 and valid=1. LE, then RESET_L=0 on the next edge, gives valid=0 and dato=0.
